// File: rtl/vreg_scoreboard_pkg.sv
`default_nettype none
// ============================================================================
// Module : vreg_scoreboard_pkg
// Brief  : Shared types and sizing constants for the vector-register scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
package vreg_scoreboard_pkg;

    localparam int SB_NUM_RID         = 4;
    localparam int SB_NUM_VREG        = 64;
    localparam int SB_MAX_OUTSTANDING = 8;
    localparam int SB_NUM_SRC         = 2;

    localparam int SB_RID_W  = $clog2(SB_NUM_RID);
    localparam int SB_VREG_W = $clog2(SB_NUM_VREG);
    localparam int SB_CNT_W  = $clog2(SB_MAX_OUTSTANDING + 1);

    typedef logic [SB_RID_W-1:0]  RsvID_t;
    typedef logic [SB_VREG_W-1:0] VRegIdx_t;
    typedef logic [4:0]           GRegIdx_t;

endpackage
`default_nettype wire

// File: rtl/vreg_scoreboard_if.sv
`default_nettype none
// ============================================================================
// Module : vreg_scoreboard_if
// Brief  : Issue request, writeback completion and status bundle of the scoreboard.
// Rev    : 1.0  initial release
// ============================================================================
interface vreg_scoreboard_if
    import vreg_scoreboard_pkg::*;
#(
    parameter int NUM_RID = SB_NUM_RID
) ();

    logic                            issueValid;
    RsvID_t                          issueRID;
    logic                            issueDstEn;
    VRegIdx_t                        issueDstVreg;
    logic [SB_NUM_SRC-1:0]           issueSrcEn;
    VRegIdx_t [SB_NUM_SRC-1:0]       issueSrcVreg;
    logic                            issueReady;

    logic                            wbValid;
    RsvID_t                          wbRID;
    VRegIdx_t                        wbVreg;

    logic [NUM_RID-1:0]              ridIdle;
    logic                            errWbUnexpected;
    RsvID_t                          errRID;

    modport master (
        output issueValid, issueRID, issueDstEn, issueDstVreg, issueSrcEn, issueSrcVreg,
        output wbValid, wbRID, wbVreg,
        input  issueReady, ridIdle, errWbUnexpected, errRID
    );

    modport slave (
        input  issueValid, issueRID, issueDstEn, issueDstVreg, issueSrcEn, issueSrcVreg,
        input  wbValid, wbRID, wbVreg,
        output issueReady, ridIdle, errWbUnexpected, errRID
    );

endinterface
`default_nettype wire

// File: rtl/rid_outstanding_ctr.sv
`default_nettype none
// ============================================================================
// Module : rid_outstanding_ctr
// Brief  : Per-RID up/down outstanding-write counter with registered idle flag.
// Rev    : 1.0  initial release
// ============================================================================
module rid_outstanding_ctr #(
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
    input  wire logic             clk,
    input  wire logic             rstn,
    input  wire logic             inc,
    input  wire logic             dec,
    output logic [CNT_W-1:0]      count,
    output logic                  idle
);

    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_OUTSTANDING);
    localparam logic [CNT_W-1:0] c_ONE = CNT_W'(1);

    logic [CNT_W-1:0] r_count;
    logic             r_idle;
    logic             w_up;
    logic             w_dn;

    // Simultaneous inc/dec nets to zero; the guards keep the count in range
    assign w_up = inc & ~dec & (r_count < c_MAX);
    assign w_dn = dec & ~inc & (r_count != '0);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_count <= '0;
            r_idle  <= 1'b1;
        end else if (w_up) begin
            r_count <= r_count + c_ONE;
            r_idle  <= 1'b0;
        end else if (w_dn) begin
            r_count <= r_count - c_ONE;
            r_idle  <= (r_count == c_ONE);
        end
    end

    assign count = r_count;
    assign idle  = r_idle;

endmodule
`default_nettype wire

// File: rtl/vreg_scoreboard.sv
`default_nettype none
// ============================================================================
// Module : vreg_scoreboard
// Brief  : Per-RID vector-register pending tracker gating issue on RAW/WAW hazards.
//          Optional macro SB_WB_BYPASS_EN lets a same-cycle writeback unblock issue.
// Rev    : 1.0  initial release
// ============================================================================
module vreg_scoreboard
    import vreg_scoreboard_pkg::*;
#(
    parameter int NUM_RID         = SB_NUM_RID,
    parameter int NUM_VREG        = SB_NUM_VREG,
    parameter int MAX_OUTSTANDING = SB_MAX_OUTSTANDING
) (
    input  wire logic         clk,
    input  wire logic         rstn,
    vreg_scoreboard_if.slave  sb
);

    localparam int               CNT_W = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [CNT_W-1:0] c_MAX = CNT_W'(MAX_OUTSTANDING);

    logic [NUM_VREG-1:0] r_pend [NUM_RID];
    logic [CNT_W-1:0]    w_cnt  [NUM_RID];
    logic [NUM_RID-1:0]  w_inc;
    logic [NUM_RID-1:0]  w_dec;
    logic [NUM_RID-1:0]  w_idle;

    logic                r_err;
    RsvID_t              r_errRID;

    logic                w_wbHit;
    logic                w_wbErr;
    logic                w_fireSet;
    logic [NUM_VREG-1:0] w_pendRow;
    logic [CNT_W-1:0]    w_cntIss;
    logic                w_hazard;

    assign w_wbHit = sb.wbValid &  r_pend[sb.wbRID][sb.wbVreg];
    assign w_wbErr = sb.wbValid & ~r_pend[sb.wbRID][sb.wbVreg];

    always_comb begin
        w_pendRow = r_pend[sb.issueRID];
        w_cntIss  = w_cnt[sb.issueRID];
`ifdef SB_WB_BYPASS_EN
        // A completing write this cycle no longer counts as a hazard or a slot
        if (w_wbHit && (sb.wbRID == sb.issueRID)) begin
            w_pendRow[sb.wbVreg] = 1'b0;
            w_cntIss             = w_cntIss - CNT_W'(1);
        end
`endif
        w_hazard = sb.issueDstEn & w_pendRow[sb.issueDstVreg];
        for (int s = 0; s < SB_NUM_SRC; s++) begin
            if (sb.issueSrcEn[s] && w_pendRow[sb.issueSrcVreg[s]]) begin
                w_hazard = 1'b1;
            end
        end
    end

    assign sb.issueReady = ~w_hazard & (w_cntIss < c_MAX);
    assign w_fireSet     = sb.issueValid & sb.issueReady & sb.issueDstEn;

    generate
        for (genvar r = 0; r < NUM_RID; r++) begin : g_rid
            assign w_inc[r] = w_fireSet & (sb.issueRID == RsvID_t'(r));
            assign w_dec[r] = w_wbHit   & (sb.wbRID    == RsvID_t'(r));

            rid_outstanding_ctr #(
                .MAX_OUTSTANDING (MAX_OUTSTANDING),
                .CNT_W           (CNT_W)
            ) u_ctr (
                .clk   (clk),
                .rstn  (rstn),
                .inc   (w_inc[r]),
                .dec   (w_dec[r]),
                .count (w_cnt[r]),
                .idle  (w_idle[r])
            );
        end
    endgenerate

    // Clear is applied before set so a same-cycle set on the same bit wins
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int r = 0; r < NUM_RID; r++) begin
                r_pend[r] <= '0;
            end
        end else begin
            for (int r = 0; r < NUM_RID; r++) begin
                if (w_dec[r]) begin
                    r_pend[r][sb.wbVreg] <= 1'b0;
                end
                if (w_inc[r]) begin
                    r_pend[r][sb.issueDstVreg] <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err    <= 1'b0;
            r_errRID <= '0;
        end else if (w_wbErr) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_errRID <= sb.wbRID;
            end
        end
    end

    assign sb.ridIdle         = w_idle;
    assign sb.errWbUnexpected = r_err;
    assign sb.errRID          = r_errRID;

endmodule
`default_nettype wire
